// File: rtl/prio_encoder_rr_if.sv
// Request/result bus of the priority encoder: input beat (req) and output beat (code/any),
// each with its own valid/ready pair.
interface prio_encoder_rr_if #(
  parameter int N = 8
);
  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0] req;
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] code;
  logic         any;

  modport master (
    output req, in_valid, out_ready,
    input  in_ready, out_valid, code, any
  );

  modport slave (
    input  req, in_valid, out_ready,
    output in_ready, out_valid, code, any
  );
endinterface

// File: rtl/prio_encoder_rr.sv
// N-to-log2(N) priority encoder with a one-deep registered output stage.
// Fixed (highest index wins) or round-robin priority, chosen by RR_MODE.
module prio_encoder_rr #(
  parameter int N       = 8,
  parameter int RR_MODE = 0
) (
  input logic             clk,
  input logic             rst,
  prio_encoder_rr_if.slave bus
);
  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] ptr;
  logic [W-1:0] sel_code;
  logic         sel_any;
  logic         capture;
  int           scan_idx;

  logic         out_valid_q;
  logic [W-1:0] code_q;
  logic         any_q;

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.code      = code_q;
  assign bus.any       = any_q;

  assign capture = bus.in_valid && bus.in_ready;

  // Descending scan from ptr with wrap modulo N; fixed mode is the same scan from N-1.
  always_comb begin
    sel_code = '0;
    sel_any  = 1'b0;
    scan_idx = 0;
    for (int i = 0; i < N; i++) begin
      scan_idx = int'(ptr) - i;
      if (scan_idx < 0) scan_idx = scan_idx + N;
      if (!sel_any && bus.req[W'(scan_idx)]) begin
        sel_any  = 1'b1;
        sel_code = W'(scan_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      code_q      <= '0;
      any_q       <= 1'b0;
    end else if (capture) begin
      out_valid_q <= 1'b1;
      code_q      <= sel_code;
      any_q       <= sel_any;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  generate
    if (RR_MODE != 0) begin : g_rr
      // The winner drops to lowest priority for the next capture.
      always_ff @(posedge clk) begin
        if (rst) begin
          ptr <= W'(N - 1);
        end else if (capture && sel_any) begin
          ptr <= (sel_code == '0) ? W'(N - 1) : sel_code - W'(1);
        end
      end
    end else begin : g_fixed
      assign ptr = W'(N - 1);
    end
  endgenerate
endmodule
